// File: rtl/vga_frame_capture.sv
// rtl/vga_frame_capture.sv - capture one IMG_W x IMG_H window of a VGA frame into the image RAM
module vga_frame_capture #(
  parameter int HDISP = 640,
  parameter int VDISP = 480,
  parameter int X0    = 0,
  parameter int Y0    = 0,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cap_en,
  input  logic        vid_hs,
  input  logic        vid_vs,
  input  logic        vid_blank,
  input  logic [7:0]  vid_data,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_we,
  output logic        busy,
  output logic        frame_done,
  output logic        err
);

  localparam int PXW = $clog2(HDISP + 1);
  localparam int LNW = $clog2(VDISP + 1);
  localparam logic [PXW-1:0] PX_MAX = PXW'(HDISP);
  localparam logic [LNW-1:0] LN_MAX = LNW'(VDISP);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

  state_t         state_q, state_d;
  logic           hs1, vs1, bl1, vs1_q, bl1_q;
  logic [7:0]     data1;
  logic [PXW-1:0] px_cnt, px;
  logic [LNW-1:0] ln_q, ln;
  logic           vs_fall, bl_rise, bl_fall;
  logic           px_in, ln_in, we_d;
  logic [7:0]     px_off, ln_off;

  // Position is rebuilt from VS and blank edges only; HS is registered but not needed.
  logic unused_hs;
  assign unused_hs = hs1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs1   <= 1'b1;
      vs1   <= 1'b1;
      bl1   <= 1'b0;
      data1 <= '0;
      vs1_q <= 1'b1;
      bl1_q <= 1'b0;
    end else begin
      hs1   <= vid_hs;
      vs1   <= vid_vs;
      bl1   <= vid_blank;
      data1 <= vid_data;
      vs1_q <= vs1;
      bl1_q <= bl1;
    end
  end

  assign vs_fall = vs1_q & ~vs1;
  assign bl_rise = bl1 & ~bl1_q;
  assign bl_fall = bl1_q & ~bl1;

  // px/ln are the coordinates of the pixel currently in stage 1.
  assign px = bl_rise ? '0 : px_cnt;
  assign ln = vs_fall ? '0 : ln_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      px_cnt <= '0;
      ln_q   <= '0;
    end else begin
      if (bl1) px_cnt <= (px == PX_MAX) ? PX_MAX : px + PXW'(1);
      else if (bl_rise) px_cnt <= '0;
      if (vs_fall) ln_q <= '0;
      else if (bl_fall && ln_q != LN_MAX) ln_q <= ln_q + LNW'(1);
    end
  end

  assign px_in  = (int'(px) >= X0) && (int'(px) <= X0 + IMG_W - 1);
  assign ln_in  = (int'(ln) >= Y0) && (int'(ln) <= Y0 + IMG_H - 1);
  assign px_off = 8'(int'(px) - X0);
  assign ln_off = 8'(int'(ln) - Y0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cap_en) state_d = ARM;
      ARM:     if (vs_fall) state_d = CAPTURE;
      CAPTURE: begin
        if (vs_fall)      state_d = DONE;
        else if (!cap_en) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == ARM) || (state_q == CAPTURE);
  assign frame_done = (state_q == DONE);

  // An abort kills the write decided in the same cycle, so ram_we drops right after.
  assign we_d = (state_q == CAPTURE) && cap_en && bl1 && px_in && ln_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      ram_we <= we_d;
      if (we_d) begin
        ram_addr <= {ln_off, px_off};
        ram_data <= data1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (state_q == IDLE && cap_en) begin
      err <= 1'b0;
    end else if (state_q == CAPTURE) begin
      if ((bl1 && px == PX_MAX) || (vs_fall && int'(ln_q) < Y0 + IMG_H)) err <= 1'b1;
    end
  end

endmodule
